// File: rtl/limb_wb_bridge_if.sv
// Wishbone classic master/slave signal bundle used by the LIMB bridge.
// Widths must match the parameters of the bridge instance that drives it.
interface limb_wb_bridge_if #(
    parameter int ADDR_W     = 36,
    parameter int DATA_BYTES = 4
);
    logic [ADDR_W-1:0]       wb_adr_o;
    logic [8*DATA_BYTES-1:0] wb_dat_o;
    logic [8*DATA_BYTES-1:0] wb_dat_i;
    logic [DATA_BYTES-1:0]   wb_sel_o;
    logic                    wb_we_o;
    logic                    wb_stb_o;
    logic                    wb_cyc_o;
    logic                    wb_ack_i;
    logic                    wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/limb_wb_bridge.sv
// LIMB (8-bit byte-serial EC bus) to Wishbone classic bridge.
// The LIMB strobe is oversampled in the Wishbone clock domain; each frame is
// an LSB-first address followed by an endless burst of auto-incrementing
// word transfers. Bus errors and timeouts raise a sticky error flag.
module limb_wb_bridge #(
    parameter int ADDR_BYTES = 5,
    parameter int ADDR_W     = 36,
    parameter int DATA_BYTES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       limb_d_in,
    output logic [7:0]       limb_d_out,
    output logic             limb_d_oe,
    input  logic             limb_clk,
    input  logic             limb_nrd,
    input  logic             limb_start,
    output logic             limb_nwait,
    limb_wb_bridge_if.master wb,
    output logic             err_o,
    input  logic             err_clr
);
    localparam int DW    = 8 * DATA_BYTES;
    localparam int CNT_W = 3;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WB_WR = 3'd3;
    localparam logic [2:0] S_WB_RD = 3'd4;

    // Synchroniser stages: {start, nrd, strobe, data} move together so all
    // fields seen in the event cycle come from the same sample.
    logic [10:0] sync1_q;
    logic [10:0] sync2_q;
    logic        lclk_prev_q;
    logic [7:0]  s_d;
    logic        s_clk;
    logic        s_nrd;
    logic        s_start;
    logic        ev;

    assign s_d     = sync2_q[7:0];
    assign s_clk   = sync2_q[8];
    assign s_nrd   = sync2_q[9];
    assign s_start = sync2_q[10];
    assign ev      = s_clk & ~lclk_prev_q;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DW-1:0]     dat_q, dat_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [7:0]        dout_q, dout_d;
    logic              rd_word_q, rd_word_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic              nwait_q, nwait_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q;
    logic              err_set;
    logic              is_rd;
    logic              rd_fetched;

    // Replace one byte lane of the word address; lanes above ADDR_W vanish.
    function automatic logic [ADDR_W-1:0] set_adr_byte(
        input logic [ADDR_W-1:0] a,
        input int                idx,
        input logic [7:0]        b
    );
        logic [ADDR_W-1:0] r;
        r = a;
        for (int i = 0; i < ADDR_W; i++) begin
            if ((i / 8) == idx) r[i] = b[i % 8];
        end
        return r;
    endfunction

    // Oversample the LIMB pins and remember the last strobe level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            lclk_prev_q <= 1'b0;
        end else begin
            sync1_q     <= {limb_start, limb_nrd, limb_clk, limb_d_in};
            sync2_q     <= sync1_q;
            lclk_prev_q <= s_clk;
        end
    end

    // Frame sequencing, byte assembly and Wishbone cycle control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rdata_d    = rdata_q;
        dout_d     = dout_q;
        rd_word_d  = rd_word_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        nwait_d    = nwait_q;
        tmo_d      = tmo_q;
        err_set    = 1'b0;
        is_rd      = 1'b0;
        rd_fetched = 1'b0;

        case (state_q)
            S_WB_WR, S_WB_RD: begin
                // The EC must not strobe while held off.
                if (ev) err_set = 1'b1;
                if (wb.wb_err_i || (!wb.wb_ack_i && tmo_q == TMO_LAST)) begin
                    err_set = 1'b1;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    nwait_d = 1'b1;
                    state_d = S_DATA;
                    if (state_q == S_WB_WR) begin
                        adr_d = adr_q + ADDR_W'(1);
                    end else begin
                        rdata_d    = '1;
                        dout_d     = 8'hFF;
                        rd_fetched = 1'b1;
                    end
                end else if (wb.wb_ack_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    nwait_d = 1'b1;
                    state_d = S_DATA;
                    if (state_q == S_WB_WR) begin
                        adr_d = adr_q + ADDR_W'(1);
                    end else begin
                        rdata_d    = wb.wb_dat_i;
                        dout_d     = wb.wb_dat_i[7:0];
                        rd_fetched = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                if (ev && s_start) begin
                    // A start strobe always restarts address capture and
                    // drops any partially assembled write word.
                    adr_d = set_adr_byte('0, 0, s_d);
                    if (ADDR_BYTES == 1) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_ADDR;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (ev && state_q == S_ADDR) begin
                    adr_d = set_adr_byte(adr_q, int'(cnt_q), s_d);
                    if (cnt_q == ADDR_LAST) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (ev && state_q == S_DATA) begin
                    // Direction is fixed per word by the first byte strobe.
                    if (cnt_q == '0) begin
                        is_rd     = ~s_nrd;
                        rd_word_d = ~s_nrd;
                    end else begin
                        is_rd = rd_word_q;
                    end
                    if (is_rd) begin
                        if (cnt_q == '0) begin
                            state_d = S_WB_RD;
                            cyc_d   = 1'b1;
                            we_d    = 1'b0;
                            nwait_d = 1'b0;
                            tmo_d   = '0;
                        end else begin
                            for (int b = 0; b < DATA_BYTES; b++) begin
                                if (b == int'(cnt_q)) dout_d = rdata_q[8*b +: 8];
                            end
                            if (cnt_q == DATA_LAST) begin
                                cnt_d = '0;
                                adr_d = adr_q + ADDR_W'(1);
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end else begin
                        for (int b = 0; b < DATA_BYTES; b++) begin
                            if (b == int'(cnt_q)) dat_d[8*b +: 8] = s_d;
                        end
                        if (cnt_q == DATA_LAST) begin
                            state_d = S_WB_WR;
                            cnt_d   = '0;
                            cyc_d   = 1'b1;
                            we_d    = 1'b1;
                            nwait_d = 1'b0;
                            tmo_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
        endcase

        // The fetch strobe itself is byte 0 of a read word, so the byte
        // counter resumes at 1; a one-byte word is complete immediately.
        if (rd_fetched) begin
            if (DATA_BYTES == 1) begin
                cnt_d = '0;
                adr_d = adr_q + ADDR_W'(1);
            end else begin
                cnt_d = CNT_W'(1);
            end
        end
    end

    // State registers; a new error outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rdata_q   <= '0;
            dout_q    <= '0;
            rd_word_q <= 1'b0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            nwait_q   <= 1'b1;
            tmo_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rdata_q   <= rdata_d;
            dout_q    <= dout_d;
            rd_word_q <= rd_word_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            nwait_q   <= nwait_d;
            tmo_q     <= tmo_d;
            err_q     <= (err_q & ~err_clr) | err_set;
        end
    end

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = '1;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_cyc_o = cyc_q;

    assign limb_d_out = dout_q;
    assign limb_d_oe  = (state_q == S_DATA) && !s_nrd;
    assign limb_nwait = nwait_q;
    assign err_o      = err_q;
endmodule

// File: tb/tb_limb_wb_bridge.sv
// Scoreboard bench for limb_wb_bridge: frame-level reference model pushes
// expected Wishbone cycles and read bytes; monitors pop and compare.
module tb_limb_wb_bridge;
    localparam int AB  = 5;
    localparam int AW  = 36;
    localparam int DB  = 4;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] limb_d_in = 8'h00;
    logic [7:0] limb_d_out;
    logic       limb_d_oe;
    logic       limb_clk = 1'b0;
    logic       limb_nrd = 1'b1;
    logic       limb_start = 1'b0;
    logic       limb_nwait;
    logic       err_o;
    logic       err_clr = 1'b0;

    always #5 clk = ~clk;

    limb_wb_bridge_if #(.ADDR_W(AW), .DATA_BYTES(DB)) wb_if ();

    limb_wb_bridge #(.ADDR_BYTES(AB), .ADDR_W(AW), .DATA_BYTES(DB), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .limb_d_in(limb_d_in), .limb_d_out(limb_d_out), .limb_d_oe(limb_d_oe),
        .limb_clk(limb_clk), .limb_nrd(limb_nrd), .limb_start(limb_start),
        .limb_nwait(limb_nwait), .wb(wb_if), .err_o(err_o), .err_clr(err_clr)
    );

    typedef enum int {K_ACK, K_ERR, K_NONE} kind_t;
    typedef struct { kind_t kind; int wt; } mode_t;
    typedef struct { logic [AW-1:0] adr; logic we; logic [DW-1:0] dat; int len; } cyc_t;

    int n_vec = 0;
    int n_bad = 0;

    cyc_t          exp_cyc_q[$];
    mode_t         mode_q[$];
    logic [7:0]    exp_byte_q[$];
    mode_t         plan[$];
    logic [DW-1:0] wdata[$];
    logic [DW-1:0] slave_mem [bit [AW-1:0]];
    logic [DW-1:0] model_mem [bit [AW-1:0]];
    bit            model_err = 1'b0;
    int            ec_reads = 0;
    int            rd_seen = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] dflt(input bit [AW-1:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ {12'h0, a[35:32]}};
    endfunction

    // Wishbone slave: one mode per cycle (ack/err after wt waits, or silence).
    initial begin : slave
        bit    s_busy = 0;
        int    s_cnt = 0;
        mode_t s_mode;
        wb_if.wb_ack_i = 1'b0;
        wb_if.wb_err_i = 1'b0;
        wb_if.wb_dat_i = '0;
        forever begin
            @(negedge clk);
            if (wb_if.wb_cyc_o && wb_if.wb_stb_o) begin
                if (!s_busy) begin
                    s_busy = 1;
                    s_cnt  = 0;
                    if (mode_q.size() > 0) s_mode = mode_q.pop_front();
                    else begin s_mode.kind = K_ACK; s_mode.wt = 0; end
                end
                if (s_mode.kind != K_NONE && s_cnt == s_mode.wt) begin
                    if (s_mode.kind == K_ERR) begin
                        wb_if.wb_err_i = 1'b1;
                        wb_if.wb_ack_i = 1'($urandom_range(0, 1));
                        wb_if.wb_dat_i = $urandom();
                    end else begin
                        wb_if.wb_ack_i = 1'b1;
                        if (wb_if.wb_we_o) slave_mem[wb_if.wb_adr_o] = wb_if.wb_dat_o;
                        else wb_if.wb_dat_i = slave_mem.exists(wb_if.wb_adr_o) ?
                                              slave_mem[wb_if.wb_adr_o] : dflt(wb_if.wb_adr_o);
                    end
                end
                s_cnt++;
            end else begin
                s_busy = 0;
                wb_if.wb_ack_i = 1'b0;
                wb_if.wb_err_i = 1'b0;
            end
        end
    end

    // Cycle monitor: compares each new Wishbone cycle and its duration.
    initial begin : cyc_mon
        bit   m_busy = 0;
        int   m_len = 0;
        cyc_t m_exp;
        forever begin
            @(negedge clk);
            if (wb_if.wb_cyc_o && wb_if.wb_stb_o) begin
                if (!m_busy) begin
                    m_busy = 1;
                    m_len  = 0;
                    if (exp_cyc_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_cycle: got adr %h expected no cycle", wb_if.wb_adr_o);
                        m_exp.len = 0;
                    end else begin
                        m_exp = exp_cyc_q.pop_front();
                        $display("cycle adr=%h we=%0d dat=%h", wb_if.wb_adr_o, wb_if.wb_we_o, wb_if.wb_dat_o);
                        check("wb_adr", 64'(wb_if.wb_adr_o), 64'(m_exp.adr));
                        check("wb_we", 64'(wb_if.wb_we_o), 64'(m_exp.we));
                        if (m_exp.we) check("wb_dat", 64'(wb_if.wb_dat_o), 64'(m_exp.dat));
                        check("wb_sel", 64'(wb_if.wb_sel_o), 64'(4'hF));
                        check("nwait_in_cycle", 64'(limb_nwait), 64'(0));
                    end
                end
                m_len++;
            end else if (m_busy) begin
                m_busy = 0;
                if (m_exp.len != 0) begin
                    check("cyc_len", 64'(m_len), 64'(m_exp.len));
                    check("nwait_after", 64'(limb_nwait), 64'(1));
                end
            end
        end
    end

    // Read-byte monitor: one compare per EC byte read.
    initial begin : byte_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            while (rd_seen < ec_reads) begin
                rd_seen++;
                if (exp_byte_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL rd_byte_extra: got %h expected none", limb_d_out);
                end else begin
                    b = exp_byte_q.pop_front();
                    check("rd_byte", 64'(limb_d_out), 64'(b));
                end
                check("rd_oe", 64'(limb_d_oe), 64'(1));
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // One LIMB strobe with setup, high and low times, then wait for nwait.
    task automatic limb_ev(input logic [7:0] d, input logic nrd, input logic st);
        int n;
        limb_d_in  = d;
        limb_nrd   = nrd;
        limb_start = st;
        repeat (3) @(negedge clk);
        limb_clk = 1'b1;
        repeat (4) @(negedge clk);
        limb_clk = 1'b0;
        repeat (4) @(negedge clk);
        n = 0;
        while (limb_nwait !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (limb_nwait !== 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL nwait_release: got %b expected 1", limb_nwait);
        end
    endtask

    task automatic send_addr(input logic [AW-1:0] a, input logic nrd, input logic [3:0] junk);
        logic [8*AB-1:0] raw;
        raw = {junk, a};
        for (int i = 0; i < AB; i++) limb_ev(raw[8*i +: 8], nrd, (i == 0));
    endtask

    task automatic write_frame(input logic [AW-1:0] a, input int n, input logic [3:0] junk);
        cyc_t          e;
        mode_t         m;
        logic [DW-1:0] d;
        $display("frame write adr=%h words=%0d", a, n);
        send_addr(a, 1'b1, junk);
        for (int w = 0; w < n; w++) begin
            m = plan.pop_front();
            d = (wdata.size() > 0) ? wdata.pop_front() : $urandom();
            e.adr = a + AW'(w);
            e.we  = 1'b1;
            e.dat = d;
            e.len = (m.kind == K_NONE) ? TMO : m.wt + 1;
            exp_cyc_q.push_back(e);
            mode_q.push_back(m);
            if (m.kind == K_ACK) model_mem[e.adr] = d;
            else model_err = 1'b1;
            for (int b = 0; b < DB; b++) limb_ev(d[8*b +: 8], 1'b1, 1'b0);
        end
    endtask

    task automatic read_frame(input logic [AW-1:0] a, input int n);
        cyc_t          e;
        mode_t         m;
        logic [DW-1:0] word;
        $display("frame read adr=%h words=%0d", a, n);
        send_addr(a, 1'b0, 4'($urandom()));
        for (int w = 0; w < n; w++) begin
            m = plan.pop_front();
            e.adr = a + AW'(w);
            e.we  = 1'b0;
            e.dat = '0;
            e.len = (m.kind == K_NONE) ? TMO : m.wt + 1;
            exp_cyc_q.push_back(e);
            mode_q.push_back(m);
            if (m.kind == K_ACK) word = model_mem.exists(e.adr) ? model_mem[e.adr] : dflt(e.adr);
            else begin word = '1; model_err = 1'b1; end
            for (int b = 0; b < DB; b++) exp_byte_q.push_back(word[8*b +: 8]);
            for (int b = 0; b < DB; b++) begin
                limb_ev(8'($urandom()), 1'b0, 1'b0);
                ec_reads++;
            end
        end
    endtask

    task automatic add_plan(input kind_t k, input int wt);
        mode_t m;
        m.kind = k;
        m.wt   = wt;
        plan.push_back(m);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        slave_mem[a] = d;
        model_mem[a] = d;
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        model_err = 1'b0;
        check("err_cleared", 64'(err_o), 64'(0));
    endtask

    task automatic frame_end_checks();
        check("err_o", 64'(err_o), 64'(model_err));
        check("nwait_idle", 64'(limb_nwait), 64'(1));
        check("cyc_idle", 64'(wb_if.wb_cyc_o), 64'(0));
    endtask

    initial begin : main
        logic [AW-1:0] a;
        logic [AW-1:0] last_wr;
        logic [63:0]   r64;
        logic [DW-1:0] wd;
        int            n;
        int            k;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cyc", 64'(wb_if.wb_cyc_o), 64'(0));
        check("rst_stb", 64'(wb_if.wb_stb_o), 64'(0));
        check("rst_we", 64'(wb_if.wb_we_o), 64'(0));
        check("rst_nwait", 64'(limb_nwait), 64'(1));
        check("rst_oe", 64'(limb_d_oe), 64'(0));
        check("rst_dout", 64'(limb_d_out), 64'(0));
        check("rst_adr", 64'(wb_if.wb_adr_o), 64'(0));
        check("rst_dat", 64'(wb_if.wb_dat_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        check("rst_sel", 64'(wb_if.wb_sel_o), 64'(4'hF));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single write with the reference byte sequence.
        add_plan(K_ACK, 2);
        wdata.push_back(32'hDDCCBBAA);
        write_frame(36'h876543210, 1, 4'h0);
        frame_end_checks();
        check("wr_dat_hold", 64'(wb_if.wb_dat_o), 64'(32'hDDCCBBAA));
        check("wr_adr_inc", 64'(wb_if.wb_adr_o), 64'(36'h876543211));

        // Two-word read burst.
        a = 36'h123456780;
        preload(a, 32'h11223344);
        preload(a + AW'(1), 32'h55667788);
        add_plan(K_ACK, 0);
        add_plan(K_ACK, 3);
        read_frame(a, 2);
        frame_end_checks();

        // Read aborted by bus error, then clear.
        add_plan(K_ERR, 1);
        read_frame(36'h0000000A0, 1);
        frame_end_checks();
        clear_err();

        // Write that never gets a response.
        add_plan(K_NONE, 0);
        write_frame(36'h0000000B0, 1, 4'h0);
        frame_end_checks();
        clear_err();

        // Start strobe in the middle of a write word discards it.
        send_addr(36'h0000000C0, 1'b1, 4'h0);
        limb_ev(8'h5A, 1'b1, 1'b0);
        limb_ev(8'hA5, 1'b1, 1'b0);
        add_plan(K_ACK, 1);
        write_frame(36'h0000000D0, 1, 4'h0);
        frame_end_checks();

        // Address wrap across the top of the word-address space.
        add_plan(K_ACK, 0);
        add_plan(K_ACK, 1);
        write_frame(36'hFFFFFFFFF, 2, 4'hF);
        frame_end_checks();
        check("wrap_adr", 64'(wb_if.wb_adr_o), 64'(36'h000000001));

        // Randomized frames.
        last_wr = 36'h876543210;
        for (int f = 0; f < 24; f++) begin
            r64 = {$urandom(), $urandom()};
            a = r64[AW-1:0];
            if ($urandom_range(0, 4) == 0) a = '1 - AW'($urandom_range(0, 2));
            n = $urandom_range(1, 3);
            for (int w = 0; w < n; w++) begin
                k = $urandom_range(0, 9);
                add_plan((k < 7) ? K_ACK : ((k < 9) ? K_ERR : K_NONE), $urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 1) == 1) a = last_wr;
                read_frame(a, n);
            end else begin
                last_wr = a;
                write_frame(a, n, 4'($urandom()));
            end
            frame_end_checks();
            if ($urandom_range(0, 2) == 0) clear_err();
        end
        clear_err();

        // Asynchronous reset while a cycle is outstanding.
        a = 36'h0000000E0;
        send_addr(a, 1'b1, 4'h0);
        wd = $urandom();
        for (int b = 0; b < 3; b++) limb_ev(wd[8*b +: 8], 1'b1, 1'b0);
        begin
            cyc_t e;
            mode_t m;
            e.adr = a; e.we = 1'b1; e.dat = wd; e.len = 0;
            exp_cyc_q.push_back(e);
            m.kind = K_NONE; m.wt = 0;
            mode_q.push_back(m);
        end
        limb_d_in = wd[31:24];
        repeat (3) @(negedge clk);
        limb_clk = 1'b1;
        n = 0;
        while (!wb_if.wb_cyc_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_cyc_up", 64'(wb_if.wb_cyc_o), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_cyc", 64'(wb_if.wb_cyc_o), 64'(0));
        check("async_rst_stb", 64'(wb_if.wb_stb_o), 64'(0));
        check("async_rst_nwait", 64'(limb_nwait), 64'(1));
        @(negedge clk);
        limb_clk = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        model_err = 1'b0;
        check("post_rst_err", 64'(err_o), 64'(0));
        add_plan(K_ACK, 0);
        write_frame(36'h0000000F0, 1, 4'h0);
        frame_end_checks();

        repeat (10) @(negedge clk);
        check("exp_cyc_left", 64'(exp_cyc_q.size()), 64'(0));
        check("exp_byte_left", 64'(exp_byte_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
